// File: rtl/smg_scan_driver_if.sv
// Bus interface for smg_scan_driver.
//   number_sig : six BCD digits to display, nibble k = digit k
//   dp_mask    : bit k lights the decimal point of digit k
//   lz_en      : leading-zero suppression enable (sampled live)
//   seg_sel    : active-low digit enables, bit k = digit k
//   seg_data   : active-low segments, [7]=dp, [6:0]=g..a
//   frame_done : one-cycle pulse on the last cycle of each frame
// master = data source / display side, slave = the scan driver.
interface smg_scan_driver_if;
  logic [23:0] number_sig;
  logic [5:0]  dp_mask;
  logic        lz_en;
  logic [5:0]  seg_sel;
  logic [7:0]  seg_data;
  logic        frame_done;

  modport master (
    output number_sig, dp_mask, lz_en,
    input  seg_sel, seg_data, frame_done
  );

  modport slave (
    input  number_sig, dp_mask, lz_en,
    output seg_sel, seg_data, frame_done
  );
endinterface

// File: rtl/smg_scan_driver.sv
// Six-digit multiplexed seven-segment scan driver.
// Snapshots the BCD word and dp mask once per frame, then scans digits 0..5, each for SCAN_DIV
// cycles, with BLANK_CYCLES all-off cycles opening every slot to suppress ghosting.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : smg_scan_driver_if.slave (inputs number_sig/dp_mask/lz_en, registered outputs
//           seg_sel/seg_data/frame_done)
module smg_scan_driver #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input logic               clk,
  input logic               rst_n,
  smg_scan_driver_if.slave  bus
);

  localparam int unsigned CntW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] LastPos  = CntW'(SCAN_DIV - 1);
  localparam logic [CntW-1:0] BlankEnd = CntW'(BLANK_CYCLES);

  // r_pos / r_digit name the slot position whose outputs the next edge registers.
  logic [CntW-1:0] r_pos;
  logic [2:0]      r_digit;
  logic [23:0]     r_num_snap;
  logic [5:0]      r_dp_snap;
  logic [5:0]      r_seg_sel;
  logic [7:0]      r_seg_data;
  logic            r_frame_done;

  logic [3:0] w_digit_val;
  logic       w_dp_bit;
  logic [5:0] w_upper_zero;
  logic       w_suppress;
  logic       w_blank;

  function automatic logic [6:0] glyph(input logic [3:0] val);
    logic [6:0] g;
    case (val)
      4'd0:    g = 7'h40;
      4'd1:    g = 7'h79;
      4'd2:    g = 7'h24;
      4'd3:    g = 7'h30;
      4'd4:    g = 7'h19;
      4'd5:    g = 7'h12;
      4'd6:    g = 7'h02;
      4'd7:    g = 7'h78;
      4'd8:    g = 7'h00;
      4'd9:    g = 7'h10;
      default: g = 7'h3F;  // dash for non-BCD nibbles
    endcase
    return g;
  endfunction

  always_comb begin
    w_digit_val = 4'd0;
    w_dp_bit    = 1'b0;
    case (r_digit)
      3'd0:    begin w_digit_val = r_num_snap[3:0];   w_dp_bit = r_dp_snap[0]; end
      3'd1:    begin w_digit_val = r_num_snap[7:4];   w_dp_bit = r_dp_snap[1]; end
      3'd2:    begin w_digit_val = r_num_snap[11:8];  w_dp_bit = r_dp_snap[2]; end
      3'd3:    begin w_digit_val = r_num_snap[15:12]; w_dp_bit = r_dp_snap[3]; end
      3'd4:    begin w_digit_val = r_num_snap[19:16]; w_dp_bit = r_dp_snap[4]; end
      3'd5:    begin w_digit_val = r_num_snap[23:20]; w_dp_bit = r_dp_snap[5]; end
      default: begin w_digit_val = 4'd0;              w_dp_bit = 1'b0;         end
    endcase
  end

  // w_upper_zero[k]: snapshot digits k..5 are all zero.
  always_comb begin
    w_upper_zero = '1;
    for (int k = 0; k < 6; k++) begin
      for (int j = k; j < 6; j++) begin
        if (r_num_snap[j*4 +: 4] != 4'd0) w_upper_zero[k] = 1'b0;
      end
    end
  end

  always_comb begin
    w_suppress = 1'b0;
    if (bus.lz_en && (r_digit != 3'd0) && (r_digit < 3'd6)) begin
      w_suppress = w_upper_zero[r_digit];
    end
    w_blank = (r_pos < BlankEnd) || w_suppress;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pos        <= '0;
      r_digit      <= '0;
      r_num_snap   <= '0;
      r_dp_snap    <= '0;
      r_seg_sel    <= 6'h3F;
      r_seg_data   <= 8'hFF;
      r_frame_done <= 1'b0;
    end else begin
      // The edge opening digit 0's slot takes the snapshot; that cycle is always blank, so the
      // stale snapshot is never displayed.
      if ((r_pos == '0) && (r_digit == 3'd0)) begin
        r_num_snap <= bus.number_sig;
        r_dp_snap  <= bus.dp_mask;
      end

      if (w_blank) begin
        r_seg_sel  <= 6'h3F;
        r_seg_data <= 8'hFF;
      end else begin
        r_seg_sel  <= ~(6'd1 << r_digit);
        r_seg_data <= {~w_dp_bit, glyph(w_digit_val)};
      end

      r_frame_done <= (r_digit == 3'd5) && (r_pos == LastPos);

      if (r_pos == LastPos) begin
        r_pos   <= '0;
        r_digit <= (r_digit == 3'd5) ? 3'd0 : r_digit + 3'd1;
      end else begin
        r_pos <= r_pos + 1'b1;
      end
    end
  end

  assign bus.seg_sel    = r_seg_sel;
  assign bus.seg_data   = r_seg_data;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_smg_scan_driver.sv
module tb_smg_scan_driver;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;

  smg_scan_driver_if bus ();

  smg_scan_driver #(
    .SCAN_DIV     (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  // One clock; sample point is 1 ns after the rising edge. cyc = 1-based frame cycle count.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Advance to the last cycle of a frame (or stay there) so new inputs land in the next snapshot.
  task automatic goto_frame_end();
    while ((cyc % 48) != 0) tick();
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.number_sig = 24'h123456;
    bus.dp_mask    = 6'h00;
    bus.lz_en      = 1'b0;
    #23;
    checks++;
    if (bus.seg_sel !== 6'h3F) begin
      errors++;
      $display("FAIL reset_seg_sel: got %h expected 3f", bus.seg_sel);
    end
    checks++;
    if (bus.seg_data !== 8'hFF) begin
      errors++;
      $display("FAIL reset_seg_data: got %h expected ff", bus.seg_data);
    end
    checks++;
    if (bus.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_frame_done: got %b expected 0", bus.frame_done);
    end
    @(posedge clk);
    #4;
    rst_n = 1'b1;
    cyc   = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.seg_sel !== 6'h3F || bus.seg_data !== 8'hFF) begin
        errors++;
        $display("FAIL reset_first_blank cyc %0d: got sel=%h data=%h expected 3f ff",
                 cyc, bus.seg_sel, bus.seg_data);
      end
    end
  endtask

  task automatic test_scan_timing();
    logic [5:0] tsel [6];
    logic [7:0] tdat [6];
    logic [5:0] es;
    logic [7:0] ed;
    int f, d, p;
    tsel = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
    tdat = '{8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    while (cyc < 56) begin
      tick();
      f  = (cyc - 1) % 48;
      d  = f / 8;
      p  = f % 8;
      es = (p < 2) ? 6'h3F : tsel[d];
      ed = (p < 2) ? 8'hFF : tdat[d];
      checks++;
      if (bus.seg_sel !== es || bus.seg_data !== ed) begin
        errors++;
        $display("FAIL scan cyc %0d: got sel=%h data=%h expected %h %h",
                 cyc, bus.seg_sel, bus.seg_data, es, ed);
      end
      checks++;
      if (bus.frame_done !== (cyc == 48)) begin
        errors++;
        $display("FAIL frame_done cyc %0d: got %b expected %b", cyc, bus.frame_done, cyc == 48);
      end
    end
  endtask

  task automatic test_glyph_dp();
    logic [7:0] tdat [6];
    logic [5:0] es;
    logic [7:0] ed;
    int d, p;
    tdat = '{8'h90, 8'h92, 8'h10, 8'h92, 8'h30, 8'hA4};
    goto_frame_end();
    bus.number_sig = 24'h235959;
    bus.dp_mask    = 6'b010100;
    bus.lz_en      = 1'b0;
    for (int i = 0; i < 48; i++) begin
      tick();
      d  = i / 8;
      p  = i % 8;
      es = (p < 2) ? 6'h3F : ~(6'd1 << d);
      ed = (p < 2) ? 8'hFF : tdat[d];
      checks++;
      if (bus.seg_sel !== es || bus.seg_data !== ed) begin
        errors++;
        $display("FAIL glyph_dp pos %0d: got sel=%h data=%h expected %h %h",
                 i, bus.seg_sel, bus.seg_data, es, ed);
      end
    end
  endtask

  task automatic test_invalid_nibble();
    logic [7:0] tdat [6];
    logic [5:0] es;
    logic [7:0] ed;
    int d, p;
    tdat = '{8'hF8, 8'hBF, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
    goto_frame_end();
    bus.number_sig = 24'h0000A7;
    bus.dp_mask    = 6'h00;
    bus.lz_en      = 1'b0;
    for (int i = 0; i < 48; i++) begin
      tick();
      d  = i / 8;
      p  = i % 8;
      es = (p < 2) ? 6'h3F : ~(6'd1 << d);
      ed = (p < 2) ? 8'hFF : tdat[d];
      checks++;
      if (bus.seg_sel !== es || bus.seg_data !== ed) begin
        errors++;
        $display("FAIL invalid_nibble pos %0d: got sel=%h data=%h expected %h %h",
                 i, bus.seg_sel, bus.seg_data, es, ed);
      end
    end
  endtask

  // lz=1 with dp set on suppressed digit 4: digits 3..5 must stay dark.
  task automatic test_lz_on();
    logic [7:0] tdat [6];
    logic [5:0] es;
    logic [7:0] ed;
    int d, p;
    tdat = '{8'h92, 8'hC0, 8'hF9, 8'hFF, 8'hFF, 8'hFF};
    goto_frame_end();
    bus.number_sig = 24'h000105;
    bus.dp_mask    = 6'b010000;
    bus.lz_en      = 1'b1;
    for (int i = 0; i < 48; i++) begin
      tick();
      d  = i / 8;
      p  = i % 8;
      es = (p < 2 || d >= 3) ? 6'h3F : ~(6'd1 << d);
      ed = (p < 2) ? 8'hFF : tdat[d];
      checks++;
      if (bus.seg_sel !== es || bus.seg_data !== ed) begin
        errors++;
        $display("FAIL lz_on pos %0d: got sel=%h data=%h expected %h %h",
                 i, bus.seg_sel, bus.seg_data, es, ed);
      end
    end
  endtask

  task automatic test_lz_off();
    logic [7:0] tdat [6];
    logic [5:0] es;
    logic [7:0] ed;
    int d, p;
    tdat = '{8'h92, 8'hC0, 8'hF9, 8'hC0, 8'hC0, 8'hC0};
    goto_frame_end();
    bus.number_sig = 24'h000105;
    bus.dp_mask    = 6'h00;
    bus.lz_en      = 1'b0;
    for (int i = 0; i < 48; i++) begin
      tick();
      d  = i / 8;
      p  = i % 8;
      es = (p < 2) ? 6'h3F : ~(6'd1 << d);
      ed = (p < 2) ? 8'hFF : tdat[d];
      checks++;
      if (bus.seg_sel !== es || bus.seg_data !== ed) begin
        errors++;
        $display("FAIL lz_off pos %0d: got sel=%h data=%h expected %h %h",
                 i, bus.seg_sel, bus.seg_data, es, ed);
      end
    end
  endtask

  // Inputs change in digit 3's slot; old frame must finish unchanged, new one shows new data.
  task automatic test_snapshot();
    logic [7:0] old_d [6];
    logic [7:0] new_d [6];
    logic [5:0] es;
    logic [7:0] ed;
    int d, p;
    old_d = '{8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    new_d = '{8'h19, 8'h12, 8'h02, 8'h78, 8'h00, 8'h10};
    goto_frame_end();
    bus.number_sig = 24'h123456;
    bus.dp_mask    = 6'h00;
    bus.lz_en      = 1'b0;
    for (int i = 0; i < 96; i++) begin
      tick();
      d  = (i % 48) / 8;
      p  = i % 8;
      es = (p < 2) ? 6'h3F : ~(6'd1 << d);
      ed = (p < 2) ? 8'hFF : ((i < 48) ? old_d[d] : new_d[d]);
      checks++;
      if (bus.seg_sel !== es || bus.seg_data !== ed) begin
        errors++;
        $display("FAIL snapshot step %0d: got sel=%h data=%h expected %h %h",
                 i, bus.seg_sel, bus.seg_data, es, ed);
      end
      if (i == 27) begin
        bus.number_sig = 24'h987654;
        bus.dp_mask    = 6'h3F;
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [5:0] es;
    logic [7:0] ed;
    goto_frame_end();
    for (int i = 0; i < 36; i++) tick();
    checks++;
    if (bus.seg_sel !== 6'h2F) begin
      errors++;
      $display("FAIL pre_reset_digit4: got sel=%h expected 2f", bus.seg_sel);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.seg_sel !== 6'h3F || bus.seg_data !== 8'hFF || bus.frame_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got sel=%h data=%h fd=%b expected 3f ff 0",
               bus.seg_sel, bus.seg_data, bus.frame_done);
    end
    bus.number_sig = 24'h000001;
    bus.dp_mask    = 6'h00;
    @(posedge clk);
    #1;
    checks++;
    if (bus.seg_sel !== 6'h3F || bus.seg_data !== 8'hFF) begin
      errors++;
      $display("FAIL reset_held: got sel=%h data=%h expected 3f ff", bus.seg_sel, bus.seg_data);
    end
    #3;
    rst_n = 1'b1;
    cyc   = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      es = (i < 2) ? 6'h3F : 6'h3E;
      ed = (i < 2) ? 8'hFF : 8'hF9;
      checks++;
      if (bus.seg_sel !== es || bus.seg_data !== ed || bus.frame_done !== 1'b0) begin
        errors++;
        $display("FAIL restart pos %0d: got sel=%h data=%h fd=%b expected %h %h 0",
                 i, bus.seg_sel, bus.seg_data, bus.frame_done, es, ed);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    test_reset();
    test_scan_timing();
    test_glyph_dp();
    test_invalid_nibble();
    test_lz_on();
    test_lz_off();
    test_snapshot();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
